// File: rtl/regfile_ldm_stm_sequencer.sv
// Block-transfer sequencer (LDM/STM/PUSH/POP): walks a register list, moves one word per register.
// Optional full-descending addressing is enabled by defining REGSEQ_DESCENDING_EN.
module regfile_ldm_stm_sequencer #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned LIST_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              is_load,
  input  logic              dec,
  input  logic [3:0]        base_reg,
  input  logic [DATA_W-1:0] base_addr,
  input  logic [LIST_W-1:0] reg_list,
  input  logic              writeback_en,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [3:0]        rf_read_addr,
  input  logic [DATA_W-1:0] rf_read_data,
  output logic [3:0]        rf_write_addr,
  output logic [DATA_W-1:0] rf_write_data,
  output logic              rf_write_en,
  output logic              pc_load_valid,
  output logic [DATA_W-1:0] pc_load_data,
  output logic              mem_req,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack
);

  localparam int unsigned CNT_W = $clog2(LIST_W + 1);
  localparam int unsigned SPAN_W = CNT_W + 2;

  typedef enum logic [2:0] {S_IDLE, S_ACCESS, S_COMMIT, S_WB, S_DONE} state_t;

  function automatic logic [3:0] lowest_bit(input logic [LIST_W-1:0] l);
    lowest_bit = '0;
    for (int i = LIST_W - 1; i >= 0; i--) begin
      if (l[i]) lowest_bit = 4'(i);
    end
  endfunction

  function automatic logic [CNT_W-1:0] popcount(input logic [LIST_W-1:0] l);
    popcount = '0;
    for (int i = 0; i < LIST_W; i++) begin
      popcount = popcount + CNT_W'(l[i]);
    end
  endfunction

  state_t              state_q, state_d;
  logic [LIST_W-1:0]   list_q, list_d;
  logic                load_q, load_d;
  logic                wb_do_q, wb_do_d;
  logic [3:0]          base_reg_q, base_reg_d;
  logic [DATA_W-1:0]   wb_val_q, wb_val_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic [3:0]          rf_read_addr_q, rf_read_addr_d;
  logic [3:0]          rf_write_addr_q, rf_write_addr_d;
  logic [DATA_W-1:0]   rf_write_data_q, rf_write_data_d;
  logic                rf_write_en_q, rf_write_en_d;
  logic                pc_load_valid_q, pc_load_valid_d;
  logic [DATA_W-1:0]   pc_load_data_q, pc_load_data_d;
  logic                mem_req_q, mem_req_d;
  logic                mem_we_q, mem_we_d;
  logic [DATA_W-1:0]   mem_addr_q, mem_addr_d;

  logic                dec_eff;
  logic [CNT_W-1:0]    cnt_c;
  logic [DATA_W-1:0]   span_c;
  logic [DATA_W-1:0]   low_addr_c;
  logic [DATA_W-1:0]   start_addr_c;
  logic [DATA_W-1:0]   end_val_c;
  logic [3:0]          cur_reg_c;
  logic [LIST_W-1:0]   list_next_c;

`ifdef REGSEQ_DESCENDING_EN
  assign dec_eff = dec;
`else
  logic unused_dec;
  assign unused_dec = dec;
  assign dec_eff    = 1'b0;
`endif

  // Descending mode still transfers lowest register at lowest address.
  assign cnt_c        = popcount(reg_list);
  assign span_c       = DATA_W'({cnt_c, 2'b00});
  assign low_addr_c   = base_addr - span_c;
  assign start_addr_c = dec_eff ? low_addr_c : base_addr;
  assign end_val_c    = dec_eff ? low_addr_c : base_addr + span_c;
  assign cur_reg_c    = lowest_bit(list_q);
  assign list_next_c  = list_q & ~(LIST_W'(1) << cur_reg_c);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= S_IDLE;
      list_q          <= '0;
      load_q          <= 1'b0;
      wb_do_q         <= 1'b0;
      base_reg_q      <= '0;
      wb_val_q        <= '0;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
      err_q           <= 1'b0;
      rf_read_addr_q  <= '0;
      rf_write_addr_q <= '0;
      rf_write_data_q <= '0;
      rf_write_en_q   <= 1'b0;
      pc_load_valid_q <= 1'b0;
      pc_load_data_q  <= '0;
      mem_req_q       <= 1'b0;
      mem_we_q        <= 1'b0;
      mem_addr_q      <= '0;
    end else begin
      state_q         <= state_d;
      list_q          <= list_d;
      load_q          <= load_d;
      wb_do_q         <= wb_do_d;
      base_reg_q      <= base_reg_d;
      wb_val_q        <= wb_val_d;
      busy_q          <= busy_d;
      done_q          <= done_d;
      err_q           <= err_d;
      rf_read_addr_q  <= rf_read_addr_d;
      rf_write_addr_q <= rf_write_addr_d;
      rf_write_data_q <= rf_write_data_d;
      rf_write_en_q   <= rf_write_en_d;
      pc_load_valid_q <= pc_load_valid_d;
      pc_load_data_q  <= pc_load_data_d;
      mem_req_q       <= mem_req_d;
      mem_we_q        <= mem_we_d;
      mem_addr_q      <= mem_addr_d;
    end
  end

  // Outputs are computed for the state being entered, so each appears registered in that state.
  always_comb begin
    state_d         = state_q;
    list_d          = list_q;
    load_d          = load_q;
    wb_do_d         = wb_do_q;
    base_reg_d      = base_reg_q;
    wb_val_d        = wb_val_q;
    busy_d          = busy_q;
    done_d          = 1'b0;
    err_d           = 1'b0;
    rf_read_addr_d  = rf_read_addr_q;
    rf_write_addr_d = rf_write_addr_q;
    rf_write_data_d = rf_write_data_q;
    rf_write_en_d   = 1'b0;
    pc_load_valid_d = 1'b0;
    pc_load_data_d  = pc_load_data_q;
    mem_req_d       = mem_req_q;
    mem_we_d        = mem_we_q;
    mem_addr_d      = mem_addr_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          list_d     = reg_list;
          load_d     = is_load;
          base_reg_d = base_reg;
          wb_val_d   = end_val_c;
          wb_do_d    = writeback_en && !(is_load && reg_list[base_reg]);
          if (cnt_c == '0) begin
            state_d = S_DONE;
            done_d  = 1'b1;
            err_d   = 1'b1;
          end else begin
            state_d        = S_ACCESS;
            busy_d         = 1'b1;
            mem_req_d      = 1'b1;
            mem_we_d       = !is_load;
            mem_addr_d     = start_addr_c;
            rf_read_addr_d = lowest_bit(reg_list);
          end
        end
      end
      S_ACCESS: begin
        if (mem_ack) begin
          state_d   = S_COMMIT;
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          if (load_q) begin
            if (cur_reg_c == 4'd15) begin
              pc_load_valid_d = 1'b1;
              pc_load_data_d  = mem_rdata & ~DATA_W'(1);
            end else begin
              rf_write_en_d   = 1'b1;
              rf_write_addr_d = cur_reg_c;
              rf_write_data_d = mem_rdata;
            end
          end
        end
      end
      S_COMMIT: begin
        list_d = list_next_c;
        if (list_next_c != '0) begin
          state_d        = S_ACCESS;
          mem_req_d      = 1'b1;
          mem_we_d       = !load_q;
          mem_addr_d     = mem_addr_q + DATA_W'(4);
          rf_read_addr_d = lowest_bit(list_next_c);
        end else begin
          state_d = S_WB;
          if (wb_do_q) begin
            rf_write_en_d   = 1'b1;
            rf_write_addr_d = base_reg_q;
            rf_write_data_d = wb_val_q;
          end
        end
      end
      S_WB: begin
        state_d = S_DONE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign err           = err_q;
  assign rf_read_addr  = rf_read_addr_q;
  assign rf_write_addr = rf_write_addr_q;
  assign rf_write_data = rf_write_data_q;
  assign rf_write_en   = rf_write_en_q;
  assign pc_load_valid = pc_load_valid_q;
  assign pc_load_data  = pc_load_data_q;
  assign mem_req       = mem_req_q;
  assign mem_we        = mem_we_q;
  assign mem_addr      = mem_addr_q;
  // Register-file read is combinational, so store data follows the registered read address.
  assign mem_wdata     = (state_q == S_ACCESS && !load_q) ? rf_read_data : '0;

endmodule

// File: tb/tb_regfile_ldm_stm_sequencer.sv
// Scoreboard bench for regfile_ldm_stm_sequencer: directed block transfers against a small memory/register-file model.
module tb_regfile_ldm_stm_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, is_load, dec, writeback_en;
  logic [3:0]  base_reg;
  logic [31:0] base_addr;
  logic [15:0] reg_list;
  logic        busy, done, err;
  logic [3:0]  rf_read_addr, rf_write_addr;
  logic [31:0] rf_read_data, rf_write_data;
  logic        rf_write_en, pc_load_valid;
  logic [31:0] pc_load_data;
  logic        mem_req, mem_we, mem_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  regfile_ldm_stm_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .is_load(is_load), .dec(dec),
    .base_reg(base_reg), .base_addr(base_addr), .reg_list(reg_list),
    .writeback_en(writeback_en), .busy(busy), .done(done), .err(err),
    .rf_read_addr(rf_read_addr), .rf_read_data(rf_read_data),
    .rf_write_addr(rf_write_addr), .rf_write_data(rf_write_data),
    .rf_write_en(rf_write_en), .pc_load_valid(pc_load_valid),
    .pc_load_data(pc_load_data), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_ack(mem_ack)
  );

  always #5 clk = ~clk;

  typedef struct { logic we; logic [31:0] addr; logic [31:0] wdata; } mem_exp_t;
  typedef struct { logic [3:0] addr; logic [31:0] data; } rf_exp_t;

  mem_exp_t    exp_mem[$];
  rf_exp_t     exp_rf[$];
  logic [31:0] exp_pc[$];
  logic        exp_err[$];
  logic [31:0] rdata_q[$];

  int n_checks = 0;
  int n_errors = 0;
  int waits = 0;
  int wcnt = 0;

  logic [31:0] regs [16];
  assign rf_read_data = (rf_read_addr == 4'd15) ? 32'h0 : regs[rf_read_addr];

  always @(posedge clk) begin
    if (!rst && rf_write_en) regs[rf_write_addr] <= rf_write_data;
  end

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic void unexpected(input string name, input logic [31:0] act);
    n_checks++;
    n_errors++;
    $display("FAIL %s: unexpected event, value 0x%08h at %0t", name, act, $time);
  endfunction

  // Memory responder: acks after `waits` wait cycles, returns queued load data.
  always @(posedge clk) begin
    #1;
    if (rst) begin
      mem_ack = 1'b0;
      wcnt    = 0;
    end else if (mem_ack) begin
      mem_ack = 1'b0;
    end else if (mem_req) begin
      if (wcnt >= waits) begin
        mem_ack = 1'b1;
        wcnt    = 0;
        if (!mem_we) mem_rdata = (rdata_q.size() != 0) ? rdata_q.pop_front() : 32'hBAD0_BAD0;
      end else begin
        wcnt++;
      end
    end
  end

  // Monitor: pops the scoreboard whenever the DUT presents an observable event.
  always @(negedge clk) begin
    if (!rst) begin
      if (mem_req && mem_ack) begin
        if (exp_mem.size() == 0) unexpected("mem_txn", mem_addr);
        else begin
          mem_exp_t e;
          e = exp_mem.pop_front();
          check("mem_we", 32'(mem_we), 32'(e.we));
          check("mem_addr", mem_addr, e.addr);
          if (e.we) check("mem_wdata", mem_wdata, e.wdata);
        end
      end
      if (rf_write_en) begin
        check("rf_write_not_r15", 32'(rf_write_addr == 4'd15), 32'd0);
        if (exp_rf.size() == 0) unexpected("rf_write", 32'(rf_write_addr));
        else begin
          rf_exp_t r;
          r = exp_rf.pop_front();
          check("rf_write_addr", 32'(rf_write_addr), 32'(r.addr));
          check("rf_write_data", rf_write_data, r.data);
        end
      end
      if (pc_load_valid) begin
        check("pc_rf_exclusive", 32'(rf_write_en), 32'd0);
        if (exp_pc.size() == 0) unexpected("pc_load", pc_load_data);
        else check("pc_load_data", pc_load_data, exp_pc.pop_front());
      end
      if (done) begin
        check("busy_at_done", 32'(busy), 32'd0);
        if (exp_err.size() == 0) unexpected("done", 32'(err));
        else check("err", 32'(err), 32'(exp_err.pop_front()));
      end else if (err) begin
        unexpected("err_without_done", 32'(err));
      end
    end
  end

  task automatic push_mem(input logic we, input logic [31:0] a, input logic [31:0] d);
    mem_exp_t e;
    e.we = we; e.addr = a; e.wdata = d;
    exp_mem.push_back(e);
  endtask

  task automatic push_rf(input logic [3:0] a, input logic [31:0] d);
    rf_exp_t r;
    r.addr = a; r.data = d;
    exp_rf.push_back(r);
  endtask

  // Issues one command and checks start-to-done latency; poke issues a second start while busy.
  task automatic run_op(input logic ld, input logic dc, input logic [3:0] br, input logic [31:0] ba,
                        input logic [15:0] rl, input logic wb, input int w, input int exp_lat,
                        input bit poke);
    int c;
    waits = w;
    @(posedge clk); #1;
    is_load = ld; dec = dc; base_reg = br; base_addr = ba; reg_list = rl; writeback_en = wb;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    c = 1;
    while (c <= 200) begin
      if (done) break;
      if (c == 2) check("busy_mid_op", 32'(busy), 32'd1);
      if (poke && c == 2) begin
        start = 1'b1; is_load = 1'b0; reg_list = 16'h0001; base_addr = 32'hDEAD_0000;
        writeback_en = 1'b1; base_reg = 4'd7;
      end
      @(posedge clk); #1;
      start = 1'b0;
      c++;
    end
    if (c > 200) unexpected("done_timeout", 32'(c));
    else check("done_latency", 32'(c), 32'(exp_lat));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; start = 1'b0; is_load = 1'b0; dec = 1'b0; base_reg = '0; base_addr = '0;
    reg_list = '0; writeback_en = 1'b0; mem_ack = 1'b0; mem_rdata = '0;
    for (int i = 0; i < 16; i++) regs[i] <= 32'h0;
    regs[1] <= 32'hA;
    regs[2] <= 32'hB;
    repeat (3) @(posedge clk);
    #2;
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_mem_req", 32'(mem_req), 32'd0);
    check("reset_rf_write_en", 32'(rf_write_en), 32'd0);
    check("reset_pc_load_valid", 32'(pc_load_valid), 32'd0);
    rst = 1'b0;

    // STM r1,r2 to 0x100 with writeback of r0
    push_mem(1'b1, 32'h100, 32'hA);
    push_mem(1'b1, 32'h104, 32'hB);
    push_rf(4'd0, 32'h108);
    exp_err.push_back(1'b0);
    run_op(1'b0, 1'b0, 4'd0, 32'h100, 16'h0006, 1'b1, 0, 6, 1'b0);

    // LDM r0,pc with 3 wait states; a second start mid-operation must be ignored
    rdata_q.push_back(32'h11);
    rdata_q.push_back(32'h305);
    push_mem(1'b0, 32'h200, 32'h0);
    push_mem(1'b0, 32'h204, 32'h0);
    push_rf(4'd0, 32'h11);
    exp_pc.push_back(32'h304);
    exp_err.push_back(1'b0);
    run_op(1'b1, 1'b0, 4'd2, 32'h200, 16'h8001, 1'b0, 3, 12, 1'b1);

    // LDM with base in list: loaded value wins, no writeback
    rdata_q.push_back(32'h55);
    push_mem(1'b0, 32'h300, 32'h0);
    push_rf(4'd4, 32'h55);
    exp_err.push_back(1'b0);
    run_op(1'b1, 1'b0, 4'd4, 32'h300, 16'h0010, 1'b1, 1, 5, 1'b0);

    // Empty list: err with done in the cycle after start, no memory activity
    exp_err.push_back(1'b1);
    run_op(1'b0, 1'b0, 4'd0, 32'h400, 16'h0000, 1'b1, 0, 1, 1'b0);

    // STM r15 stores zero; writeback to r3
    push_mem(1'b1, 32'h400, 32'h0);
    push_rf(4'd3, 32'h404);
    exp_err.push_back(1'b0);
    run_op(1'b0, 1'b0, 4'd3, 32'h400, 16'h8000, 1'b1, 0, 4, 1'b0);

    // Reset while a request is pending
    waits = 50;
    @(posedge clk); #1;
    is_load = 1'b0; dec = 1'b0; base_reg = 4'd6; base_addr = 32'h500; reg_list = 16'h00FF;
    writeback_en = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check("pre_reset_mem_req", 32'(mem_req), 32'd1);
    rst = 1'b1;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_mem_req", 32'(mem_req), 32'd0);
    check("abort_mem_addr", mem_addr, 32'h0);
    check("abort_mem_we", 32'(mem_we), 32'd0);
    check("abort_rf_read_addr", 32'(rf_read_addr), 32'd0);
    check("abort_rf_write_en", 32'(rf_write_en), 32'd0);
    repeat (2) @(posedge clk);
    #3;
    rst = 1'b0;

    // Normal operation after the abort
    push_mem(1'b1, 32'h100, 32'hA);
    push_mem(1'b1, 32'h104, 32'hB);
    push_rf(4'd0, 32'h108);
    exp_err.push_back(1'b0);
    run_op(1'b0, 1'b0, 4'd0, 32'h100, 16'h0006, 1'b1, 0, 6, 1'b0);

    // Address wrap modulo 2^32
    rdata_q.push_back(32'h77);
    rdata_q.push_back(32'h88);
    push_mem(1'b0, 32'hFFFF_FFFC, 32'h0);
    push_mem(1'b0, 32'h0000_0000, 32'h0);
    push_rf(4'd0, 32'h77);
    push_rf(4'd1, 32'h88);
    push_rf(4'd5, 32'h4);
    exp_err.push_back(1'b0);
    run_op(1'b1, 1'b0, 4'd5, 32'hFFFF_FFFC, 16'h0003, 1'b1, 0, 6, 1'b0);

    // PUSH {r0,r1,r14} with dec=1
    @(posedge clk);
    regs[0]  <= 32'hA0;
    regs[1]  <= 32'hA1;
    regs[14] <= 32'hAE;
`ifdef REGSEQ_DESCENDING_EN
    push_mem(1'b1, 32'hFF4, 32'hA0);
    push_mem(1'b1, 32'hFF8, 32'hA1);
    push_mem(1'b1, 32'hFFC, 32'hAE);
    push_rf(4'd13, 32'hFF4);
`else
    push_mem(1'b1, 32'h1000, 32'hA0);
    push_mem(1'b1, 32'h1004, 32'hA1);
    push_mem(1'b1, 32'h1008, 32'hAE);
    push_rf(4'd13, 32'h100C);
`endif
    exp_err.push_back(1'b0);
    run_op(1'b0, 1'b1, 4'd13, 32'h1000, 16'h4003, 1'b1, 0, 8, 1'b0);

    repeat (4) @(posedge clk);
    #1;
    check("exp_mem_left", 32'(exp_mem.size()), 32'd0);
    check("exp_rf_left", 32'(exp_rf.size()), 32'd0);
    check("exp_pc_left", 32'(exp_pc.size()), 32'd0);
    check("exp_done_left", 32'(exp_err.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
